// File: rtl/cache_ctrl_nway_if.sv
// CPU load/store port and block-wide memory port of the N-way cache controller.
// The controller connects through the slave modport; the CPU/memory side uses master.
interface cache_ctrl_nway_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 512
);
  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic              cpu_req_rw;
  logic [31:0]       cpu_req_wdata;
  logic              cpu_resp_valid;
  logic [31:0]       cpu_resp_rdata;
  logic              mem_rd_valid;
  logic              mem_wr_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [LINE_W-1:0] mem_rdata;
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;

  modport slave (
    input  cpu_req_valid, cpu_req_addr, cpu_req_rw, cpu_req_wdata, mem_ack, mem_rdata,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, mem_rd_valid, mem_wr_valid,
           mem_addr, mem_wdata, hit_count, miss_count
  );

  modport master (
    output cpu_req_valid, cpu_req_addr, cpu_req_rw, cpu_req_wdata, mem_ack, mem_rdata,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, mem_rd_valid, mem_wr_valid,
           mem_addr, mem_wdata, hit_count, miss_count
  );
endinterface

// File: rtl/cache_ctrl_nway.sv
// N-way set-associative cache controller: true-LRU age counters, acknowledged
// memory handshake, write-back or write-through policy, saturating hit/miss counters.
module cache_ctrl_nway #(
  parameter int ADDR_W          = 32,
  parameter int NUM_WAYS        = 4,
  parameter int NUM_SETS        = 128,
  parameter int WORDS_PER_BLOCK = 16,
  parameter int WRITE_BACK      = 1
) (
  input logic              clk,
  input logic              rst_n,
  cache_ctrl_nway_if.slave bus
);
  localparam int WI_W   = $clog2(WORDS_PER_BLOCK);
  localparam int OFF_W  = WI_W + 2;
  localparam int SET_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = ADDR_W - SET_W - OFF_W;
  localparam int LINE_W = 32 * WORDS_PER_BLOCK;
  localparam int WAY_W  = $clog2(NUM_WAYS);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_WRITEBACK = 3'd2;
  localparam logic [2:0] S_FILL      = 3'd3;
  localparam logic [2:0] S_WTHRU     = 3'd4;
  localparam logic [2:0] S_RESP      = 3'd5;

  logic [2:0]          r_state;
  logic [ADDR_W-1:2]   r_addr;
  logic                r_rw;
  logic [31:0]         r_wdata;
  logic [WAY_W-1:0]    r_way;
  logic                r_resp_valid;
  logic [31:0]         r_resp_rdata;
  logic                r_mem_rd;
  logic                r_mem_wr;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [LINE_W-1:0]   r_mem_wdata;
  logic [31:0]         r_hit_cnt;
  logic [31:0]         r_miss_cnt;

  logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
  logic [NUM_WAYS-1:0] r_dirty [NUM_SETS];
  logic [WAY_W-1:0]    r_age   [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]    r_tag   [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]   r_data  [NUM_SETS][NUM_WAYS];

  logic [TAG_W-1:0]    w_tag;
  logic [SET_W-1:0]    w_set;
  logic [WI_W-1:0]     w_word;
  logic                w_hit;
  logic [WAY_W-1:0]    w_hit_way;
  logic                w_inv_found;
  logic [WAY_W-1:0]    w_inv_way;
  logic [WAY_W-1:0]    w_lru_way;
  logic [WAY_W-1:0]    w_victim;
  logic                w_vic_dirty;
  logic [LINE_W-1:0]   w_hit_merged;
  logic [LINE_W-1:0]   w_fill_line;
  logic [LINE_W-1:0]   w_acc_line;
  logic [WAY_W-1:0]    w_old_age;
  logic [ADDR_W-1:0]   w_req_line_addr;

  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                   input logic [WI_W-1:0]   idx,
                                                   input logic [31:0]       data);
    logic [LINE_W-1:0] l;
    l = line;
    l[int'(idx) * 32 +: 32] = data;
    return l;
  endfunction

  assign w_tag           = r_addr[ADDR_W-1 -: TAG_W];
  assign w_set           = r_addr[OFF_W +: SET_W];
  assign w_word          = r_addr[2 +: WI_W];
  assign w_req_line_addr = {w_tag, w_set, {OFF_W{1'b0}}};

  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    w_lru_way   = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (r_valid[w_set][w] && (r_tag[w_set][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!r_valid[w_set][w] && !w_inv_found) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAY_W'(w);
      end
      if (r_age[w_set][w] == WAY_W'(NUM_WAYS - 1)) w_lru_way = WAY_W'(w);
    end
  end

  assign w_victim     = w_inv_found ? w_inv_way : w_lru_way;
  assign w_vic_dirty  = r_valid[w_set][w_victim] && r_dirty[w_set][w_victim];
  assign w_hit_merged = merge_word(r_data[w_set][w_hit_way], w_word, r_wdata);
  assign w_fill_line  = r_rw ? merge_word(bus.mem_rdata, w_word, r_wdata) : bus.mem_rdata;
  assign w_acc_line   = r_data[w_set][r_way];
  assign w_old_age    = r_age[w_set][r_way];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_rw         <= 1'b0;
      r_wdata      <= '0;
      r_way        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) r_age[s][w] <= WAY_W'(w);
      end
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cpu_req_valid) begin
            r_addr  <= bus.cpu_req_addr[ADDR_W-1:2];
            r_rw    <= bus.cpu_req_rw;
            r_wdata <= bus.cpu_req_wdata;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_way <= w_hit_way;
            if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
            if (r_rw && (WRITE_BACK == 0)) begin
              r_mem_wr    <= 1'b1;
              r_mem_addr  <= w_req_line_addr;
              r_mem_wdata <= w_hit_merged;
              r_state     <= S_WTHRU;
            end else begin
              if (r_rw) r_dirty[w_set][w_hit_way] <= 1'b1;
              r_state <= S_RESP;
            end
          end else begin
            r_way <= w_victim;
            if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
            if (w_vic_dirty) begin
              r_mem_wr    <= 1'b1;
              r_mem_addr  <= {r_tag[w_set][w_victim], w_set, {OFF_W{1'b0}}};
              r_mem_wdata <= r_data[w_set][w_victim];
              r_state     <= S_WRITEBACK;
            end else begin
              r_mem_rd   <= 1'b1;
              r_mem_addr <= w_req_line_addr;
              r_state    <= S_FILL;
            end
          end
        end
        S_WRITEBACK: begin
          if (bus.mem_ack) begin
            r_dirty[w_set][r_way] <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= w_req_line_addr;
            r_state    <= S_FILL;
          end
        end
        S_FILL: begin
          if (bus.mem_ack) begin
            r_valid[w_set][r_way] <= 1'b1;
            r_dirty[w_set][r_way] <= r_rw && (WRITE_BACK != 0);
            r_mem_rd <= 1'b0;
            if (r_rw && (WRITE_BACK == 0)) begin
              r_mem_wr    <= 1'b1;
              r_mem_wdata <= w_fill_line;
              r_state     <= S_WTHRU;
            end else begin
              r_state <= S_RESP;
            end
          end
        end
        S_WTHRU: begin
          if (bus.mem_ack) begin
            r_mem_wr <= 1'b0;
            r_state  <= S_RESP;
          end
        end
        S_RESP: begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= w_acc_line[int'(w_word) * 32 +: 32];
          // Only valid ways younger than the accessed one age, so invalid ways keep their reset ages.
          for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (WAY_W'(w) == r_way)
              r_age[w_set][w] <= '0;
            else if (r_valid[w_set][w] && (r_age[w_set][w] < w_old_age))
              r_age[w_set][w] <= r_age[w_set][w] + 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line storage needs no reset: the valid bits alone decide what is cached.
  always_ff @(posedge clk) begin
    if ((r_state == S_LOOKUP) && w_hit && r_rw)
      r_data[w_set][w_hit_way] <= w_hit_merged;
    if ((r_state == S_FILL) && bus.mem_ack) begin
      r_data[w_set][r_way] <= w_fill_line;
      r_tag[w_set][r_way]  <= w_tag;
    end
  end

  assign bus.cpu_req_ready  = (r_state == S_IDLE);
  assign bus.cpu_resp_valid = r_resp_valid;
  assign bus.cpu_resp_rdata = r_resp_rdata;
  assign bus.mem_rd_valid   = r_mem_rd;
  assign bus.mem_wr_valid   = r_mem_wr;
  assign bus.mem_addr       = r_mem_addr;
  assign bus.mem_wdata      = r_mem_wdata;
  assign bus.hit_count      = r_hit_cnt;
  assign bus.miss_count     = r_miss_cnt;
endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Bench for cache_ctrl_nway: a write-back and a write-through instance, one selected at a time,
// checked against a recency-ordered line model plus a line-addressed memory model.
module tb_cache_ctrl_nway;
  localparam int LW = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0;
  logic [31:0]   req_addr = '0;
  logic          req_rw = 1'b0;
  logic [31:0]   req_wdata = '0;
  logic          mem_ack = 1'b0;
  logic [LW-1:0] mem_rdata = '0;

  cache_ctrl_nway_if #(.ADDR_W(32), .LINE_W(LW)) bwb ();
  cache_ctrl_nway_if #(.ADDR_W(32), .LINE_W(LW)) bwt ();

  assign bwb.cpu_req_valid = req_valid & ~sel;
  assign bwt.cpu_req_valid = req_valid & sel;
  assign bwb.mem_ack       = mem_ack & ~sel;
  assign bwt.mem_ack       = mem_ack & sel;
  assign bwb.cpu_req_addr  = req_addr;
  assign bwt.cpu_req_addr  = req_addr;
  assign bwb.cpu_req_rw    = req_rw;
  assign bwt.cpu_req_rw    = req_rw;
  assign bwb.cpu_req_wdata = req_wdata;
  assign bwt.cpu_req_wdata = req_wdata;
  assign bwb.mem_rdata     = mem_rdata;
  assign bwt.mem_rdata     = mem_rdata;

  cache_ctrl_nway #(.ADDR_W(32), .NUM_WAYS(4), .NUM_SETS(128), .WORDS_PER_BLOCK(16), .WRITE_BACK(1))
    dut_wb (.clk(clk), .rst_n(rst_n), .bus(bwb));
  cache_ctrl_nway #(.ADDR_W(32), .NUM_WAYS(4), .NUM_SETS(128), .WORDS_PER_BLOCK(16), .WRITE_BACK(0))
    dut_wt (.clk(clk), .rst_n(rst_n), .bus(bwt));

  logic          o_ready, o_resp, o_rd, o_wr;
  logic [31:0]   o_rdata, o_maddr, o_hits, o_misses;
  logic [LW-1:0] o_mwdata;
  assign o_ready  = sel ? bwt.cpu_req_ready  : bwb.cpu_req_ready;
  assign o_resp   = sel ? bwt.cpu_resp_valid : bwb.cpu_resp_valid;
  assign o_rdata  = sel ? bwt.cpu_resp_rdata : bwb.cpu_resp_rdata;
  assign o_rd     = sel ? bwt.mem_rd_valid   : bwb.mem_rd_valid;
  assign o_wr     = sel ? bwt.mem_wr_valid   : bwb.mem_wr_valid;
  assign o_maddr  = sel ? bwt.mem_addr       : bwb.mem_addr;
  assign o_mwdata = sel ? bwt.mem_wdata      : bwb.mem_wdata;
  assign o_hits   = sel ? bwt.hit_count      : bwb.hit_count;
  assign o_misses = sel ? bwt.miss_count     : bwb.miss_count;

  int n_tests = 0;
  int n_fail = 0;
  int force_delay = -1;

  // Reference model: main memory by line address, cached lines with last-use stamps.
  logic [LW-1:0] mem    [logic [31:0]];
  logic [LW-1:0] cdata  [logic [31:0]];
  bit            cdirty [logic [31:0]];
  longint        stamp  [logic [31:0]];
  longint        tick = 0;
  bit            wb_mode = 1'b1;
  int unsigned   exp_hits = 0;
  int unsigned   exp_miss = 0;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] memline(input logic [31:0] la);
    logic [LW-1:0] l;
    if (mem.exists(la)) return mem[la];
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = la + 32'(4 * k);
    return l;
  endfunction

  function automatic int unsigned set_of(input logic [31:0] a);
    return int'((a >> 6) % 128);
  endfunction

  task automatic model_reset();
    cdata.delete();
    cdirty.delete();
    stamp.delete();
    exp_hits = 0;
    exp_miss = 0;
  endtask

  task automatic mem_op(input bit is_wr, input logic [31:0] ea, input logic [LW-1:0] eline,
                        inout int cyc, inout int lat_exp);
    int d;
    d = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
    check(is_wr ? "wr_addr" : "rd_addr", o_maddr, ea);
    if (is_wr) check("wr_data", o_mwdata, eline);
    repeat (d) begin
      @(negedge clk); cyc++;
      check("hold_valid", is_wr ? o_wr : o_rd, 1'b1);
      check("hold_addr", o_maddr, ea);
      check("excl_valid", o_rd & o_wr, 1'b0);
    end
    mem_rdata = is_wr ? '0 : eline;
    mem_ack = 1'b1;
    @(negedge clk); cyc++;
    mem_ack = 1'b0;
    lat_exp += 1 + d;
  endtask

  task automatic access(input bit rw, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] la, vic;
    logic [LW-1:0] fill_line, wb_line, wt_line, tmp;
    logic [31:0] exp_rd;
    bit hit, need_wb, need_fill, need_wt, done, spur;
    int cnt, cyc, lat_exp, word;
    longint best;
    la = addr & ~32'h3F;
    word = int'(addr[5:2]);
    vic = '0; wb_line = '0; wt_line = '0; fill_line = '0;
    hit = cdata.exists(la);
    need_wb = 1'b0; need_fill = !hit; need_wt = 1'b0;
    if (!hit) begin
      exp_miss++;
      cnt = 0; best = 64'h7FFF_FFFF_FFFF_FFFF;
      foreach (cdata[k]) begin
        if (set_of(k) == set_of(la)) begin
          cnt++;
          if (stamp[k] < best) begin best = stamp[k]; vic = k; end
        end
      end
      if (cnt == 4) begin
        if (cdirty[vic]) begin
          need_wb = 1'b1;
          wb_line = cdata[vic];
          mem[vic] = wb_line;
        end
        cdata.delete(vic); cdirty.delete(vic); stamp.delete(vic);
      end
      fill_line = memline(la);
      cdata[la] = fill_line;
      cdirty[la] = 1'b0;
    end else begin
      exp_hits++;
    end
    if (rw) begin
      tmp = cdata[la];
      tmp[word*32 +: 32] = wd;
      cdata[la] = tmp;
      if (wb_mode) cdirty[la] = 1'b1;
      else begin
        need_wt = 1'b1;
        wt_line = tmp;
        mem[la] = tmp;
      end
    end
    tmp = cdata[la];
    exp_rd = tmp[word*32 +: 32];
    tick++;
    stamp[la] = tick;

    check("req_ready", o_ready, 1'b1);
    req_valid = 1'b1; req_addr = addr; req_rw = rw; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; lat_exp = 2; done = 1'b0;
    spur = ($urandom_range(0, 3) == 0);
    while (!done && cyc < 200) begin
      if (o_rd || o_wr) check("excl_valid", o_rd & o_wr, 1'b0);
      if (o_resp) begin
        check("resp_rdata", o_rdata, exp_rd);
        check("latency", cyc - 1, lat_exp);
        check("pending_mem_ops", {need_wb, need_fill, need_wt}, 3'b000);
        check("hit_count", o_hits, exp_hits);
        check("miss_count", o_misses, exp_miss);
        done = 1'b1;
      end else if (o_wr) begin
        if (need_wb) begin
          mem_op(1'b1, vic, wb_line, cyc, lat_exp); need_wb = 1'b0;
        end else if (need_wt && !need_fill) begin
          mem_op(1'b1, la, wt_line, cyc, lat_exp); need_wt = 1'b0;
        end else begin
          check("unexpected_wr", o_wr, 1'b0);
          @(negedge clk); cyc++;
        end
      end else if (o_rd) begin
        if (need_fill && !need_wb) begin
          mem_op(1'b0, la, fill_line, cyc, lat_exp); need_fill = 1'b0;
        end else begin
          check("unexpected_rd", o_rd, 1'b0);
          @(negedge clk); cyc++;
        end
      end else begin
        // A stray ack while no memory request is valid must be ignored.
        if (cyc == 1) begin mem_ack = spur; mem_rdata = {16{32'hBAD0_BAD0}}; end
        @(negedge clk); cyc++;
        mem_ack = 1'b0;
      end
    end
    if (!done) check("resp_timeout", done, 1'b1);
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h0010_0000 + 32'($urandom_range(0, 5)) * 32'h2000
         + 32'($urandom_range(0, 3)) * 32'h40 + 32'($urandom_range(0, 15)) * 4;
  endfunction

  initial begin
    int cyc;
    // Reset values of the write-back instance.
    repeat (3) @(negedge clk);
    check("rst_resp_valid", o_resp, 1'b0);
    check("rst_rd_valid", o_rd, 1'b0);
    check("rst_wr_valid", o_wr, 1'b0);
    check("rst_rdata", o_rdata, 32'h0);
    check("rst_mem_addr", o_maddr, 32'h0);
    check("rst_mem_wdata", o_mwdata, '0);
    check("rst_hits", o_hits, 32'h0);
    check("rst_misses", o_misses, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", o_ready, 1'b1);

    // Cold read with a 5-cycle memory ack, then hits including a write hit.
    force_delay = 5;
    access(1'b0, 32'h0000_1040, 32'h0);
    force_delay = -1;
    access(1'b0, 32'h0000_1040, 32'h0);
    access(1'b1, 32'h0000_1048, 32'hDEAD_BEEF);
    access(1'b0, 32'h0000_1048, 32'h0);
    check("hit_count_3", o_hits, 32'd3);
    check("miss_count_1", o_misses, 32'd1);

    // Five lines in set 1: the dirty LRU line is written back before the fifth fill.
    access(1'b1, 32'h0000_0048, 32'hDEAD_BEEF);
    for (int k = 1; k < 5; k++) access(1'b0, 32'h40 + 32'(k) * 32'h2000, 32'h0);
    access(1'b0, 32'h0000_0040, 32'h0);
    check("reaccess_missed", o_misses, 32'd7);

    for (int i = 0; i < 300; i++) access($urandom_range(0, 1) == 1, rand_addr(), $urandom);

    // Reset asserted while a fill is outstanding.
    req_valid = 1'b1; req_addr = 32'h7000_0040; req_rw = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (!o_rd && cyc < 20) begin @(negedge clk); cyc++; end
    check("fill_pending", o_rd, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_drop_rd", o_rd, 1'b0);
    check("rst_drop_wr", o_wr, 1'b0);
    check("rst_no_resp", o_resp, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    access(1'b0, 32'h7000_0040, 32'h0);
    check("miss_after_reset", o_misses, 32'd1);

    // Write-through instance.
    sel = 1'b1;
    wb_mode = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    access(1'b0, 32'h0000_0040, 32'h0);
    access(1'b1, 32'h0000_0044, 32'h1234_5678);
    for (int k = 1; k < 5; k++) access(1'b0, 32'h40 + 32'(k) * 32'h2000, 32'h0);
    access(1'b0, 32'h0000_0044, 32'h0);
    for (int i = 0; i < 150; i++) access($urandom_range(0, 1) == 1, rand_addr(), $urandom);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_ctrl_nway.md
Name: cache_ctrl_nway

Overview:
- Parametrised N-way set-associative cache controller; successor to the fixed 4-way, fixed-delay controller.
- Sits between the CPU load/store port and a block-wide memory port, with valid/ready handshakes on both sides.
- Adds over the previous generation:
  - true-LRU age counters scaled to any way count;
  - a real memory acknowledge instead of a hard-coded delay;
  - selectable write-back or write-through policy;
  - hit/miss statistics counters.

Parameters:
- ADDR_W, 32, byte address width.
- NUM_WAYS, 4, associativity; power of 2, 2..16.
- NUM_SETS, 128, sets; power of 2.
- WORDS_PER_BLOCK, 16, 32-bit words per line; power of 2.
- WRITE_BACK, 1. 1 = write-back with dirty bits; 0 = write-through, lines never dirty.
- Derived widths:
  - OFF_W = log2(WORDS_PER_BLOCK) + 2
  - SET_W = log2(NUM_SETS)
  - TAG_W = ADDR_W - SET_W - OFF_W
  - LINE_W = 32 * WORDS_PER_BLOCK

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- cpu_req_valid, in, 1: request present.
- cpu_req_ready, out, 1: controller can accept a request.
- cpu_req_addr, in, ADDR_W: byte address; bits [1:0] ignored.
- cpu_req_rw, in, 1: 0 = read, 1 = write.
- cpu_req_wdata, in, 32: write data.
- cpu_resp_valid, out, 1: one-cycle response pulse.
- cpu_resp_rdata, out, 32: read data; for writes it carries the written word.
- mem_rd_valid, out, 1: line fill request.
- mem_wr_valid, out, 1: line write request.
- mem_addr, out, ADDR_W: line-aligned address; offset bits are 0.
- mem_wdata, out, LINE_W: line to write.
- mem_ack, in, 1: memory completes the outstanding request.
- mem_rdata, in, LINE_W: fill data, valid in the mem_ack cycle.
- hit_count, out, 32: saturating count of hits.
- miss_count, out, 32: saturating count of misses.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all valid and dirty bits cleared;
  - way w of every set gets age w;
  - FSM goes to IDLE;
  - cpu_resp_valid, mem_rd_valid, mem_wr_valid = 0;
  - cpu_resp_rdata, mem_addr, mem_wdata = 0;
  - hit_count, miss_count = 0;
  - cpu_req_ready = 1 once reset is released.
- Reset mid-transaction: the outstanding memory request is abandoned, no response is issued, and the cache contents are lost.
- FSM states: IDLE, LOOKUP, WRITEBACK, FILL, WTHRU, RESP.
- IDLE:
  - cpu_req_ready = 1 in this state only.
  - On valid && ready, latch addr, rw and wdata, then go to LOOKUP.
- LOOKUP:
  - Compare the tag across all ways of the set; a hit requires valid && tag match.
  - Hit, read: go to RESP.
  - Hit, write: merge the word into the line.
    - WRITE_BACK = 1: set dirty, go to RESP.
    - WRITE_BACK = 0: go to WTHRU.
  - Hit counter: +1 on any hit.
  - Miss: miss_count +1, then pick a victim.
    - Victim is the lowest-index invalid way; if all ways are valid, the way with age NUM_WAYS-1.
    - Victim valid && dirty: go to WRITEBACK; otherwise go to FILL.
- WRITEBACK:
  - mem_wr_valid = 1, mem_addr = {victim tag, set, 0}, mem_wdata = victim line, all held stable.
  - On mem_ack: clear dirty and go to FILL.
- FILL:
  - mem_rd_valid = 1, mem_addr = {req tag, set, 0}.
  - On mem_ack: install mem_rdata with the tag and valid = 1.
  - If the request is a write, merge wdata into the addressed word in the same cycle; dirty = WRITE_BACK.
  - Go to RESP, or to WTHRU for a write when WRITE_BACK = 0.
- WTHRU:
  - mem_wr_valid = 1 with the updated line at the request line address.
  - On mem_ack: go to RESP.
- RESP:
  - cpu_resp_valid = 1 for exactly one cycle, with cpu_resp_rdata = the addressed word after any merge.
  - Update the LRU of the accessed way, then return to IDLE.
- LRU update for accessed way w with old age a:
  - every valid way in the set with age < a increments;
  - w becomes age 0;
  - ages stay a permutation of 0..NUM_WAYS-1.
- Latency:
  - hit = 2 cycles from acceptance to cpu_resp_valid;
  - clean miss = 3 + fill ack wait;
  - dirty miss adds the writeback ack wait.
- mem_ack while no memory request is valid is ignored.
- mem_rd_valid and mem_wr_valid are never both high.
- Counters saturate at 0xFFFFFFFF with no wrap.

Test Plan:
- Read 0x0000_1040 after reset, fill data = word k holds 0x1040 + 4k, ack after 5 cycles -> mem_rd_valid with mem_addr 0x1040; response 0x1040; miss_count = 1.
- Repeat the same read, then write 0xDEADBEEF to 0x1048 and read 0x1048 -> hits with 2-cycle latency; read returns 0xDEADBEEF; hit_count = 3; no memory traffic (WRITE_BACK = 1).
- Five lines mapping to set 1 (addresses 0x40 + k·0x2000, k = 0..4), accessed in order, then re-access k = 0 -> fifth fill evicts k = 0 (the LRU way); re-accessing k = 0 misses.
- Dirty eviction -> mem_wr_valid with the victim address and the line holding 0xDEADBEEF precedes mem_rd_valid; nothing proceeds until each ack.
- WRITE_BACK = 0, write hit -> WTHRU line write is issued; a later eviction of that line produces no writeback.
- rst_n low during FILL -> all mem valids drop immediately; the next read of the same address misses.
